change_dispenser: RTL

- Consumer side of the controller's change interface: accepts a change request (amount in credit units) and pays it out one coin at a time to a three-tube coin hopper.
- Greedy largest-denomination-first selection, per-tube stock tracking, a per-coin hopper acknowledge handshake with timeout, and shortage/jam fault reporting.
- Sits between the vending controller (drives change_req/change_amount) and the hopper driver.

---
 rtl/vend_pkg.sv | 42 ++++
 rtl/change_dispenser_coin_selector.sv | 40 ++++
 rtl/change_dispenser.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/vend_pkg.sv
// Shared definitions for the change dispenser: state encoding, tube indices,
// default denominations and the saturating tube-count update.
package vend_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SELECT   = 3'd1;
    localparam logic [2:0] ST_FIRE     = 3'd2;
    localparam logic [2:0] ST_WAIT_ACK = 3'd3;
    localparam logic [2:0] ST_DONE     = 3'd4;
    localparam logic [2:0] ST_FAULT    = 3'd5;

    typedef enum logic [2:0] {
        IDLE     = ST_IDLE,
        SELECT   = ST_SELECT,
        FIRE     = ST_FIRE,
        WAIT_ACK = ST_WAIT_ACK,
        DONE     = ST_DONE,
        FAULT    = ST_FAULT
    } state_e;

    localparam logic [1:0] TUBE0 = 2'd0;
    localparam logic [1:0] TUBE1 = 2'd1;
    localparam logic [1:0] TUBE2 = 2'd2;

    localparam int unsigned DEF_DENOM0      = 1;
    localparam int unsigned DEF_DENOM1      = 2;
    localparam int unsigned DEF_DENOM2      = 5;
    localparam int unsigned DEF_INIT_STOCK  = 8;
    localparam int unsigned DEF_ACK_TIMEOUT = 16;

    // Refill and ack-decrement may land together; add first so the sum saturates once.
    function automatic logic [3:0] stock_next(input logic [3:0] cur, input logic add_en,
                                              input logic [3:0] add, input logic dec);
        logic [4:0] sum;
        sum = {1'b0, cur} + (add_en ? {1'b0, add} : 5'd0);
        if (dec && (sum != 5'd0)) begin
            sum = sum - 5'd1;
        end
        return (sum > 5'd15) ? 4'd15 : sum[3:0];
    endfunction

endpackage

// File: rtl/change_dispenser_coin_selector.sv
// Combinational greedy pick: highest-value tube whose coin fits the amount owed
// and that still holds at least one coin.
module coin_selector
    import vend_pkg::*;
#(
    parameter int unsigned DENOM0 = DEF_DENOM0,
    parameter int unsigned DENOM1 = DEF_DENOM1,
    parameter int unsigned DENOM2 = DEF_DENOM2
) (
    input  logic [7:0] remaining_i,
    input  logic [3:0] stock0_i,
    input  logic [3:0] stock1_i,
    input  logic [3:0] stock2_i,
    output logic [1:0] sel_o,
    output logic       found_o
);

    localparam logic [7:0] D0 = 8'(DENOM0);
    localparam logic [7:0] D1 = 8'(DENOM1);
    localparam logic [7:0] D2 = 8'(DENOM2);

    // Later assignments override earlier ones, so the largest fitting tube wins.
    always_comb begin
        sel_o   = TUBE0;
        found_o = 1'b0;
        if ((stock0_i != 4'd0) && (D0 <= remaining_i)) begin
            sel_o   = TUBE0;
            found_o = 1'b1;
        end
        if ((stock1_i != 4'd0) && (D1 <= remaining_i)) begin
            sel_o   = TUBE1;
            found_o = 1'b1;
        end
        if ((stock2_i != 4'd0) && (D2 <= remaining_i)) begin
            sel_o   = TUBE2;
            found_o = 1'b1;
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Pays a change request out coin by coin to a three-tube hopper; first coin_fire two cycles after request,
// then one coin per hopper_ack. Defining CHANGE_DISPENSER_STATS_EN adds coins_paid/value_paid counters.
module change_dispenser
    import vend_pkg::*;
#(
    parameter int unsigned DENOM0      = DEF_DENOM0,
    parameter int unsigned DENOM1      = DEF_DENOM1,
    parameter int unsigned DENOM2      = DEF_DENOM2,
    parameter int unsigned INIT_STOCK  = DEF_INIT_STOCK,
    parameter int unsigned ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        change_req,
    input  logic [7:0]  change_amount,
    input  logic        hopper_ack,
    input  logic        refill,
    input  logic [1:0]  refill_sel,
    input  logic [3:0]  refill_count,
    output logic        busy,
    output logic        coin_fire,
    output logic [1:0]  coin_sel,
    output logic [7:0]  remaining,
    output logic        done_pulse,
    output logic        short_flag,
    output logic        jam_flag,
`ifdef CHANGE_DISPENSER_STATS_EN
    output logic [15:0] coins_paid,
    output logic [15:0] value_paid,
`endif
    output logic [3:0]  stock0,
    output logic [3:0]  stock1,
    output logic [3:0]  stock2
);

    localparam int unsigned      TW         = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TW-1:0]    TIMER_LAST = TW'(ACK_TIMEOUT - 1);
    localparam logic [3:0]       STOCK_RST  = 4'(INIT_STOCK);

    state_e        state_q, state_d;
    logic [7:0]    remaining_q, remaining_d;
    logic [1:0]    tube_q, tube_d;
    logic [1:0]    coin_sel_q, coin_sel_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          short_q, short_d;
    logic          jam_q, jam_d;
    logic          done_q, done_d;
    logic          busy_q, fire_q;
    logic [3:0]    stock_q [3];
    logic [3:0]    stock_d [3];
    logic          ack_dec;
    logic [1:0]    pick;
    logic          found;
    logic [7:0]    denom_sel;

    coin_selector #(
        .DENOM0 (DENOM0),
        .DENOM1 (DENOM1),
        .DENOM2 (DENOM2)
    ) u_coin_selector (
        .remaining_i (remaining_q),
        .stock0_i    (stock_q[0]),
        .stock1_i    (stock_q[1]),
        .stock2_i    (stock_q[2]),
        .sel_o       (pick),
        .found_o     (found)
    );

    always_comb begin
        case (tube_q)
            TUBE1:   denom_sel = 8'(DENOM1);
            TUBE2:   denom_sel = 8'(DENOM2);
            default: denom_sel = 8'(DENOM0);
        endcase
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        tube_d      = tube_q;
        coin_sel_d  = coin_sel_q;
        timer_d     = timer_q;
        short_d     = short_q;
        jam_d       = jam_q;
        done_d      = 1'b0;
        ack_dec     = 1'b0;
        case (state_q)
            IDLE: begin
                if (change_req) begin
                    short_d = 1'b0;
                    jam_d   = 1'b0;
                    if (change_amount != 8'd0) begin
                        remaining_d = change_amount;
                        state_d     = SELECT;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            SELECT: begin
                if (remaining_q == 8'd0) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end else if (found) begin
                    tube_d     = pick;
                    coin_sel_d = pick;
                    state_d    = FIRE;
                end else begin
                    short_d = 1'b1;
                    state_d = FAULT;
                end
            end
            FIRE: begin
                timer_d = '0;
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (hopper_ack) begin
                    ack_dec     = 1'b1;
                    remaining_d = remaining_q - denom_sel;
                    state_d     = SELECT;
                end else if (timer_q == TIMER_LAST) begin
                    jam_d   = 1'b1;
                    state_d = FAULT;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            stock_d[i] = stock_next(stock_q[i], refill && (refill_sel == 2'(i)), refill_count,
                                    ack_dec && (tube_q == 2'(i)));
        end
    end

    // Outputs are registered from next-state so they line up with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            remaining_q <= 8'd0;
            tube_q      <= TUBE0;
            coin_sel_q  <= TUBE0;
            timer_q     <= '0;
            short_q     <= 1'b0;
            jam_q       <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            fire_q      <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                stock_q[i] <= STOCK_RST;
            end
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            tube_q      <= tube_d;
            coin_sel_q  <= coin_sel_d;
            timer_q     <= timer_d;
            short_q     <= short_d;
            jam_q       <= jam_d;
            done_q      <= done_d;
            busy_q      <= (state_d != IDLE);
            fire_q      <= (state_d == FIRE);
            for (int i = 0; i < 3; i++) begin
                stock_q[i] <= stock_d[i];
            end
        end
    end

`ifdef CHANGE_DISPENSER_STATS_EN
    logic [15:0] coins_q, value_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            coins_q <= 16'd0;
            value_q <= 16'd0;
        end else if (ack_dec) begin
            coins_q <= coins_q + 16'd1;
            value_q <= value_q + {8'd0, denom_sel};
        end
    end

    assign coins_paid = coins_q;
    assign value_paid = value_q;
`endif

    assign busy       = busy_q;
    assign coin_fire  = fire_q;
    assign coin_sel   = coin_sel_q;
    assign remaining  = remaining_q;
    assign done_pulse = done_q;
    assign short_flag = short_q;
    assign jam_flag   = jam_q;
    assign stock0     = stock_q[0];
    assign stock1     = stock_q[1];
    assign stock2     = stock_q[2];

endmodule
